// File: rtl/pixel_compositor.sv
// Breakout final pixel stage: priority colour select, game-over dimming/blinking message, sync delay alignment.
// Optional SCANLINE_EN macro enables odd-line halving driven by an hsync-edge line parity bit.
module pixel_compositor #(
  parameter int unsigned SYNC_DLY     = 2,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        video_on_in,
  input  logic [23:0] bg_rgb,
  input  logic        brick_active,
  input  logic        paddle_active,
  input  logic        ball_active,
  input  logic        msg_active,
  input  logic [23:0] brick_rgb,
  input  logic [23:0] paddle_rgb,
  input  logic [23:0] ball_rgb,
  input  logic [23:0] msg_rgb,
  input  logic        game_over_evt,
  input  logic        restart,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        over
);

  localparam int unsigned CW    = 24;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {PLAY, OVER} state_t;

  function automatic logic [CW-1:0] halve(input logic [CW-1:0] c);
    return (c >> 1) & 24'h7F7F7F;
  endfunction

  logic [SYNC_DLY-1:0] hs_q, vs_q, von_q;
  logic                vs_prev_q;
  logic                von_mid_c;
  logic                frame_tick_c;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vis_q, vis_d;
  logic                over_q;

  logic [CW-1:0]       game_c, sel_c, rgb_d, rgb_q;

  // Timing delay chains; sync stages idle high so outputs stay deasserted while refilling.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q      <= '1;
      vs_q      <= '1;
      von_q     <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      hs_q      <= {hs_q[SYNC_DLY-2:0], hsync_in};
      vs_q      <= {vs_q[SYNC_DLY-2:0], vsync_in};
      von_q     <= {von_q[SYNC_DLY-2:0], video_on_in};
      vs_prev_q <= vsync_in;
    end
  end

  assign von_mid_c    = von_q[SYNC_DLY-2];
  assign frame_tick_c = vs_prev_q & ~vsync_in;

`ifdef SCANLINE_EN
  logic                hs_prev_q;
  logic [SYNC_DLY-2:0] par_q;
  logic                line_par_c;
  logic                par_mid_c;

  // Parity of the line the timing inputs are on this cycle; frame start forces an even line.
  always_comb begin
    line_par_c = par_q[0];
    if (frame_tick_c) begin
      line_par_c = 1'b0;
    end else if (hs_prev_q && !hsync_in) begin
      line_par_c = ~par_q[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_prev_q <= 1'b1;
      par_q     <= '0;
    end else begin
      hs_prev_q <= hsync_in;
      par_q[0]  <= line_par_c;
      for (int i = 1; i < int'(SYNC_DLY) - 1; i++) begin
        par_q[i] <= par_q[i-1];
      end
    end
  end

  assign par_mid_c = par_q[SYNC_DLY-2];
`endif

  // Play/game-over state, blink counter and message visibility.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vis_d   = vis_q;
    case (state_q)
      PLAY: begin
        if (game_over_evt) begin
          state_d = OVER;
          cnt_d   = '0;
          vis_d   = 1'b1;
        end
      end
      OVER: begin
        if (restart) begin
          state_d = PLAY;
          cnt_d   = '0;
          vis_d   = 1'b1;
        end else if (frame_tick_c) begin
          if (cnt_q == BLINK_LAST) begin
            cnt_d = '0;
            vis_d = ~vis_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // Colour selection: game layers by priority, dimmed in OVER, message overrides undimmed.
  always_comb begin
    game_c = bg_rgb;
    if (ball_active) begin
      game_c = ball_rgb;
    end else if (paddle_active) begin
      game_c = paddle_rgb;
    end else if (brick_active) begin
      game_c = brick_rgb;
    end
    sel_c = game_c;
    if (state_q == OVER) begin
      sel_c = halve(game_c);
      if (msg_active && vis_q) begin
        sel_c = msg_rgb;
      end
    end
`ifdef SCANLINE_EN
    if (par_mid_c) begin
      sel_c = halve(sel_c);
    end
`endif
    rgb_d = von_mid_c ? sel_c : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PLAY;
      cnt_q   <= '0;
      vis_q   <= 1'b1;
      over_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vis_q   <= vis_d;
      over_q  <= (state_d == OVER);
      rgb_q   <= rgb_d;
    end
  end

  assign red     = rgb_q[23:16];
  assign green   = rgb_q[15:8];
  assign blue    = rgb_q[7:0];
  assign hsync   = hs_q[SYNC_DLY-1];
  assign vsync   = vs_q[SYNC_DLY-1];
  assign blank_n = von_q[SYNC_DLY-1];
  assign over    = over_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor (SYNC_DLY=2, BLINK_FRAMES=2): priority table, blink, restart, blanking, reset.
module tb_pixel_compositor;

  logic        clock = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in, video_on_in;
  logic [23:0] bg_rgb, brick_rgb, paddle_rgb, ball_rgb, msg_rgb;
  logic        brick_active, paddle_active, ball_active, msg_active;
  logic        game_over_evt, restart;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, blank_n, over;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ball;
    logic        paddle;
    logic        brick;
    logic        msg;
    logic        evt;
    logic        rst;
    logic [23:0] exp_rgb;
    logic        exp_over;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  pixel_compositor #(.SYNC_DLY(2), .BLINK_FRAMES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .video_on_in   (video_on_in),
    .bg_rgb        (bg_rgb),
    .brick_active  (brick_active),
    .paddle_active (paddle_active),
    .ball_active   (ball_active),
    .msg_active    (msg_active),
    .brick_rgb     (brick_rgb),
    .paddle_rgb    (paddle_rgb),
    .ball_rgb      (ball_rgb),
    .msg_rgb       (msg_rgb),
    .game_over_evt (game_over_evt),
    .restart       (restart),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync         (hsync),
    .vsync         (vsync),
    .blank_n       (blank_n),
    .over          (over)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk24(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk24({name, "_rgb"}, {red, green, blue}, 24'h000000);
    chk1({name, "_hsync"}, hsync, 1'b1);
    chk1({name, "_vsync"}, vsync, 1'b1);
    chk1({name, "_blank_n"}, blank_n, 1'b0);
    chk1({name, "_over"}, over, 1'b0);
  endtask

  task automatic vs_edge();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
  endtask

  task automatic set_layers(input logic ba, input logic pa, input logic br, input logic ms);
    ball_active   = ba;
    paddle_active = pa;
    brick_active  = br;
    msg_active    = ms;
  endtask

  initial begin
    logic prev_von;
    logic von;

    // ball, paddle, brick, msg, evt, restart, expected rgb, expected over
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00FF00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFF0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000040, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFF0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFF0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFF0000, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h7F0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h7F7F7F, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h007F00, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000020, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h7F0000, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFF0000, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFF0000, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 1'b1};

    reset         = 1'b1;
    hsync_in      = 1'b1;
    vsync_in      = 1'b1;
    video_on_in   = 1'b1;
    bg_rgb        = 24'h000040;
    brick_rgb     = 24'hFF0000;
    paddle_rgb    = 24'h00FF00;
    ball_rgb      = 24'hFFFFFF;
    msg_rgb       = 24'hFFFFFF;
    set_layers(1'b0, 1'b0, 1'b0, 1'b0);
    game_over_evt = 1'b0;
    restart       = 1'b0;

    repeat (3) step();
    chk_reset_state("init_reset");
    reset = 1'b0;
    step();
    step();
    chk1("init_blank_n", blank_n, 1'b1);

    // Layer priority, dimming and FSM transitions, one pipeline cycle per row
    for (int i = 0; i < NVEC; i++) begin
      set_layers(vecs[i].ball, vecs[i].paddle, vecs[i].brick, vecs[i].msg);
      game_over_evt = vecs[i].evt;
      restart       = vecs[i].rst;
      step();
      chk24($sformatf("vec%0d_rgb", i), {red, green, blue}, vecs[i].exp_rgb);
      chk1($sformatf("vec%0d_over", i), over, vecs[i].exp_over);
    end
    game_over_evt = 1'b0;
    restart       = 1'b0;

    // Blink with BLINK_FRAMES=2: hidden after 2 frame ticks, shown again after 4
    set_layers(1'b0, 1'b0, 1'b1, 1'b1);
    vs_edge(); chk24("blink_e1", {red, green, blue}, 24'hFFFFFF);
    vs_edge(); chk24("blink_e2", {red, green, blue}, 24'h7F0000);
    vs_edge(); chk24("blink_e3", {red, green, blue}, 24'h7F0000);
    vs_edge(); chk24("blink_e4", {red, green, blue}, 24'hFFFFFF);
    vs_edge(); chk24("blink_e5", {red, green, blue}, 24'hFFFFFF);

    // Restart coincident with a frame tick returns to PLAY
    vsync_in = 1'b0;
    restart  = 1'b1;
    step();
    restart  = 1'b0;
    vsync_in = 1'b1;
    chk1("restart_tick_over", over, 1'b0);
    step();
    chk24("restart_tick_rgb", {red, green, blue}, 24'hFF0000);
    chk1("restart_tick_over2", over, 1'b0);

    // Re-entry must clear the blink counter: one tick keeps the message visible
    game_over_evt = 1'b1;
    step();
    game_over_evt = 1'b0;
    chk1("reenter_over", over, 1'b1);
    step();
    chk24("reenter_msg", {red, green, blue}, 24'hFFFFFF);
    vs_edge(); chk24("reenter_e1", {red, green, blue}, 24'hFFFFFF);
    vs_edge(); chk24("reenter_e2", {red, green, blue}, 24'h7F0000);

    restart = 1'b1;
    step();
    restart = 1'b0;
    chk1("back_to_play", over, 1'b0);

    // Blanking window of 10 cycles with all layers active
    set_layers(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    prev_von = 1'b1;
    for (int i = 0; i < 14; i++) begin
      von = (i >= 2 && i < 12) ? 1'b0 : 1'b1;
      video_on_in = von;
      step();
      chk24($sformatf("blank%0d_rgb", i), {red, green, blue}, prev_von ? 24'hFFFFFF : 24'h000000);
      chk1($sformatf("blank%0d_blank_n", i), blank_n, prev_von);
      prev_von = von;
    end

    // Mid-frame reset while in OVER with syncs asserted
    game_over_evt = 1'b1;
    step();
    game_over_evt = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    step();
    step();
    chk1("pre_reset_over", over, 1'b1);
    chk1("pre_reset_hsync", hsync, 1'b0);
    chk1("pre_reset_vsync", vsync, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_state($sformatf("mid_reset%0d", i));
    end
    reset = 1'b0;
    step();
    chk1("refill1_hsync", hsync, 1'b1);
    chk1("refill1_vsync", vsync, 1'b1);
    step();
    chk1("refill2_hsync", hsync, 1'b0);
    chk1("refill2_vsync", vsync, 1'b0);
    chk1("refill2_blank_n", blank_n, 1'b1);
    chk1("refill2_over", over, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
